wb_sram_ctrl: RTL

- Wishbone classic slave that fronts NUM_BANKS OpenRAM 1rw1r SRAM macros (port 0 only) inside the user project area.
- Decodes a base-address window, selects a bank, drives active-low macro controls from registered commands, and absorbs the macro read latency.
- Generates a proper single-cycle wbs_ack_o per transfer.
- Replaces direct wiring of Wishbone signals onto a single macro.

---
 rtl/wb_sram_pkg.sv | 23 ++
 rtl/wb_sram_ctrl_if.sv | 25 ++
 rtl/wb_sram_bank_mux.sv | 23 ++
 rtl/wb_sram_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/wb_sram_pkg.sv
// Shared types and helpers for the Wishbone-to-OpenRAM bank controller.
package wb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_e;

  // Read data returned for accesses that fall outside the window
  localparam logic [31:0] MISS_RDATA = 32'h0000_0000;

  function automatic int bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 0;
  endfunction

  // Width of a bank index signal; never zero so a single bank still has a port
  function automatic int bank_sel_w(input int num_banks);
    return (bank_w(num_banks) > 0) ? bank_w(num_banks) : 1;
  endfunction

endpackage

// File: rtl/wb_sram_ctrl_if.sv
// Wishbone classic slave-side bus bundle for the SRAM controller.
interface wb_sram_ctrl_if #(
  parameter int DATA_W = 32
);

  logic                  wbs_stb_i;
  logic                  wbs_cyc_i;
  logic                  wbs_we_i;
  logic [DATA_W/8-1:0]   wbs_sel_i;
  logic [31:0]           wbs_adr_i;
  logic [DATA_W-1:0]     wbs_dat_i;
  logic                  wbs_ack_o;
  logic [DATA_W-1:0]     wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/wb_sram_bank_mux.sv
// Combinational NUM_BANKS:1 selector over the flattened macro read-data bus.
module wb_sram_bank_mux #(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 2
) (
  input  logic [NUM_BANKS*DATA_W-1:0] dout_flat,
  input  logic [SEL_W-1:0]            bank_sel,
  output logic [DATA_W-1:0]           rdata
);

  logic [DATA_W-1:0] bank_data_s [NUM_BANKS];

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_split
    assign bank_data_s[k] = dout_flat[k*DATA_W +: DATA_W];
  end

  // Select the addressed bank's read port
  always_comb begin
    rdata = bank_data_s[bank_sel];
  end

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave fronting NUM_BANKS OpenRAM macros (port 0): window
// decode, bank select, registered active-low macro controls, read-latency wait.
module wb_sram_ctrl
  import wb_sram_pkg::*;
#(
  parameter int          NUM_BANKS = 4,
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          READ_LAT  = 1
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  wb_sram_ctrl_if.slave               wbs,
  output logic [NUM_BANKS-1:0]        sram_csb0_o,
  output logic                        sram_web0_o,
  output logic [DATA_W/8-1:0]         sram_wmask0_o,
  output logic [ADDR_W-1:0]           sram_addr0_o,
  output logic [DATA_W-1:0]           sram_din0_o,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_dout0_i
);

  localparam int BANK_W  = bank_w(NUM_BANKS);
  localparam int SEL_W   = bank_sel_w(NUM_BANKS);
  localparam int MASK_W  = DATA_W / 8;
  localparam int TAG_LSB = ADDR_W + 2 + BANK_W;
  localparam int CNT_W   = 2;

  state_e                state_r, state_nxt_s;
  logic                  req_s, hit_s;
  logic [ADDR_W-1:0]     word_s;
  logic [SEL_W-1:0]      bank_s;
  logic [DATA_W-1:0]     rdata_s;

  logic [NUM_BANKS-1:0]  csb_r, csb_nxt_s;
  logic                  web_r, web_nxt_s;
  logic [MASK_W-1:0]     wmask_r, wmask_nxt_s;
  logic [ADDR_W-1:0]     addr_r, addr_nxt_s;
  logic [DATA_W-1:0]     din_r, din_nxt_s;
  logic                  we_r, we_nxt_s;
  logic [SEL_W-1:0]      bank_r, bank_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic                  ack_r, ack_nxt_s;
  logic [DATA_W-1:0]     rdata_r, rdata_nxt_s;

  assign req_s  = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_r;
  assign hit_s  = (wbs.wbs_adr_i >> TAG_LSB) == (BASE_ADDR >> TAG_LSB);
  assign word_s = wbs.wbs_adr_i[2 +: ADDR_W];
  // Masking with NUM_BANKS-1 keeps the single-bank case at index 0
  assign bank_s = SEL_W'((wbs.wbs_adr_i >> (ADDR_W + 2)) & 32'(NUM_BANKS - 1));

  wb_sram_bank_mux #(
    .NUM_BANKS (NUM_BANKS),
    .DATA_W    (DATA_W),
    .SEL_W     (SEL_W)
  ) u_bank_mux (
    .dout_flat (sram_dout0_i),
    .bank_sel  (bank_r),
    .rdata     (rdata_s)
  );

  // FSM state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-output decode; every bus output is registered
  always_comb begin
    state_nxt_s = state_r;
    csb_nxt_s   = {NUM_BANKS{1'b1}};
    web_nxt_s   = 1'b1;
    wmask_nxt_s = {MASK_W{1'b0}};
    addr_nxt_s  = addr_r;
    din_nxt_s   = din_r;
    we_nxt_s    = we_r;
    bank_nxt_s  = bank_r;
    cnt_nxt_s   = cnt_r;
    ack_nxt_s   = 1'b0;
    rdata_nxt_s = {DATA_W{1'b0}};

    case (state_r)
      IDLE: begin
        if (req_s && hit_s) begin
          state_nxt_s = ACCESS;
          we_nxt_s    = wbs.wbs_we_i;
          bank_nxt_s  = bank_s;
          csb_nxt_s   = ~(NUM_BANKS'(1) << bank_s);
          web_nxt_s   = ~wbs.wbs_we_i;
          wmask_nxt_s = wbs.wbs_we_i ? wbs.wbs_sel_i : {MASK_W{1'b0}};
          addr_nxt_s  = word_s;
          din_nxt_s   = wbs.wbs_dat_i;
        end else if (req_s) begin
          // Out-of-window: complete immediately, writes are dropped
          state_nxt_s = ACK;
          ack_nxt_s   = 1'b1;
          rdata_nxt_s = DATA_W'(MISS_RDATA);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (!wbs.wbs_cyc_i) begin
          state_nxt_s = IDLE;
        end else if (we_r) begin
          state_nxt_s = ACK;
          ack_nxt_s   = wbs.wbs_stb_i;
        end else begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = CNT_W'(READ_LAT - 1);
        end
      end
      WAIT: begin
        if (!wbs.wbs_cyc_i) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ACK;
          ack_nxt_s   = wbs.wbs_stb_i;
          rdata_nxt_s = wbs.wbs_stb_i ? rdata_s : {DATA_W{1'b0}};
        end else begin
          cnt_nxt_s   = cnt_r - CNT_W'(1);
        end
      end
      ACK: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      csb_r   <= {NUM_BANKS{1'b1}};
      web_r   <= 1'b1;
      wmask_r <= {MASK_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      din_r   <= {DATA_W{1'b0}};
      we_r    <= 1'b0;
      bank_r  <= {SEL_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ack_r   <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      csb_r   <= csb_nxt_s;
      web_r   <= web_nxt_s;
      wmask_r <= wmask_nxt_s;
      addr_r  <= addr_nxt_s;
      din_r   <= din_nxt_s;
      we_r    <= we_nxt_s;
      bank_r  <= bank_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ack_r   <= ack_nxt_s;
      rdata_r <= rdata_nxt_s;
    end
  end

  assign wbs.wbs_ack_o = ack_r;
  assign wbs.wbs_dat_o = rdata_r;
  assign sram_csb0_o   = csb_r;
  assign sram_web0_o   = web_r;
  assign sram_wmask0_o = wmask_r;
  assign sram_addr0_o  = addr_r;
  assign sram_din0_o   = din_r;

endmodule
